// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: instruction-memory request/ack, redirect input and decode-side
// valid/ready output, bundled so the fetch unit and its environment share one port.
interface instruction_fetch_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic        RedirectValid;
    logic [31:0] RedirectTarget;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Instruction;
    logic [31:0] OutPC;
    logic [31:0] OutPCPlus4;

    modport master (
        output ImemReq, ImemAddr, OutValid, Instruction, OutPC, OutPCPlus4,
        input  ImemAck, ImemData, RedirectValid, RedirectTarget, OutReady
    );

    modport slave (
        input  ImemReq, ImemAddr, OutValid, Instruction, OutPC, OutPCPlus4,
        output ImemAck, ImemData, RedirectValid, RedirectTarget, OutReady
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one word request at a time, buffers up to two
// fetched {instruction, PC} pairs for decode, and flushes on branch redirect.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                Clk,
    input  logic                Reset,
    instruction_fetch_if.master bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] instr_q [2];
    logic [31:0] instr_d [2];
    logic [31:0] pc_q [2];
    logic [31:0] pc_d [2];

    logic        redirect;
    logic [31:0] redirect_tgt;
    logic        push;
    logic        pop;
    logic        wr_slot;

    always_comb begin
        redirect     = bus.RedirectValid;
        redirect_tgt = bus.RedirectTarget & ~32'h3;
        push         = (state_q == REQ) && bus.ImemAck && !redirect;
        pop          = (count_q != 2'd0) && bus.OutReady && !redirect;
        // Entry 0 is always the head; a push lands behind whatever survives the pop.
        wr_slot      = pop ? (count_q == 2'd2) : (count_q == 2'd1);
    end

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        count_d = count_q;
        if (redirect) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                instr_d[0] = instr_q[1];
                pc_d[0]    = pc_q[1];
            end
            if (push) begin
                instr_d[wr_slot] = bus.ImemData;
                pc_d[wr_slot]    = req_addr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_tgt;
                end else if (count_q < 2'd2) begin
                    state_d    = REQ;
                    req_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (bus.ImemAck) begin
                    if (redirect) begin
                        fetch_pc_d = redirect_tgt;
                        req_addr_d = redirect_tgt;
                    end else begin
                        fetch_pc_d = req_addr_q + 32'd4;
                        if (count_d < 2'd2) begin
                            req_addr_d = req_addr_q + 32'd4;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (redirect) begin
                    // The bus request cannot be withdrawn; wait it out and drop the data.
                    fetch_pc_d = redirect_tgt;
                    state_d    = DISCARD;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    fetch_pc_d = redirect_tgt;
                end
                if (bus.ImemAck) begin
                    state_d    = REQ;
                    req_addr_d = fetch_pc_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            count_q    <= 2'd0;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
        end
    end

    assign bus.ImemReq     = (state_q == REQ) || (state_q == DISCARD);
    assign bus.ImemAddr    = req_addr_q;
    assign bus.OutValid    = (count_q != 2'd0);
    assign bus.Instruction = instr_q[0];
    assign bus.OutPC       = pc_q[0];
    assign bus.OutPCPlus4  = pc_q[0] + 32'd4;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run scored
// against an in-order program-counter stream model with a latency-varying memory.
module tb_instruction_fetch;

    logic Clk;
    logic Reset;
    logic Reset2;

    int checks   = 0;
    int failures = 0;

    bit mem_busy = 0;
    int mem_wait = 0;

    instruction_fetch_if bus ();
    instruction_fetch_if bus2 ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    instruction_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .Clk   (Clk),
        .Reset (Reset2),
        .bus   (bus2)
    );

    // Zero-wait memory for the wrap instance.
    assign bus2.ImemAck  = bus2.ImemReq;
    assign bus2.ImemData = mem_word(bus2.ImemAddr);

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Answers the current request after lat extra cycles; optionally drives junk acks while idle.
    task automatic mem_respond(input int lat, input bit spurious);
        if (bus.ImemReq) begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_wait = lat;
            end
            if (mem_wait == 0) begin
                bus.ImemAck  = 1'b1;
                bus.ImemData = mem_word(bus.ImemAddr);
                mem_busy     = 0;
            end else begin
                bus.ImemAck  = 1'b0;
                bus.ImemData = $urandom;
                mem_wait     = mem_wait - 1;
            end
        end else begin
            bus.ImemAck  = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.ImemData = $urandom;
        end
    endtask

    task automatic do_reset;
        Reset              = 1'b1;
        bus.RedirectValid  = 1'b0;
        bus.RedirectTarget = 32'h0;
        bus.OutReady       = 1'b0;
        bus.ImemAck        = 1'b0;
        bus.ImemData       = 32'h0;
        tick();
        tick();
        Reset    = 1'b0;
        mem_busy = 0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({bus.ImemReq, bus.OutValid, bus.ImemAddr} !== {1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_ctrl: req/valid/addr got %b/%b/%h expected 0/0/00000000",
                     bus.ImemReq, bus.OutValid, bus.ImemAddr);
        end
        checks++;
        if ({bus.Instruction, bus.OutPC, bus.OutPCPlus4} !== {32'h0, 32'h0, 32'h4}) begin
            failures++;
            $display("FAIL reset_out: instr/pc/pc4 got %h/%h/%h expected 00000000/00000000/00000004",
                     bus.Instruction, bus.OutPC, bus.OutPCPlus4);
        end
    endtask

    task automatic test_stream;
        logic [31:0] e;
        do_reset();
        bus.OutReady = 1'b1;
        mem_respond(0, 0);
        tick();
        checks++;
        if ({bus.ImemReq, bus.ImemAddr, bus.OutValid} !== {1'b1, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL stream_first_req: req/addr/valid got %b/%h/%b expected 1/00000000/0",
                     bus.ImemReq, bus.ImemAddr, bus.OutValid);
        end
        mem_respond(0, 0);
        tick();
        for (int i = 0; i < 12; i++) begin
            e = 32'(i * 4);
            checks++;
            if ({bus.OutValid, bus.OutPC, bus.OutPCPlus4, bus.Instruction} !==
                {1'b1, e, e + 32'd4, mem_word(e)}) begin
                failures++;
                $display("FAIL stream_%0d: valid/pc/pc4/instr got %b/%h/%h/%h expected 1/%h/%h/%h",
                         i, bus.OutValid, bus.OutPC, bus.OutPCPlus4, bus.Instruction,
                         e, e + 32'd4, mem_word(e));
            end
            mem_respond(0, 0);
            tick();
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        bus.OutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_respond(0, 0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({bus.ImemReq, bus.OutValid, bus.OutPC, bus.Instruction} !==
                {1'b0, 1'b1, 32'h0, mem_word(32'h0)}) begin
                failures++;
                $display("FAIL bp_full_%0d: req/valid/pc/instr got %b/%b/%h/%h expected 0/1/00000000/%h",
                         i, bus.ImemReq, bus.OutValid, bus.OutPC, bus.Instruction, mem_word(32'h0));
            end
            mem_respond(0, 0);
            tick();
        end
        bus.OutReady = 1'b1;
        mem_respond(0, 0);
        tick();
        bus.OutReady = 1'b0;
        checks++;
        if ({bus.ImemReq, bus.OutValid, bus.OutPC} !== {1'b0, 1'b1, 32'h4}) begin
            failures++;
            $display("FAIL bp_pop: req/valid/pc got %b/%b/%h expected 0/1/00000004",
                     bus.ImemReq, bus.OutValid, bus.OutPC);
        end
        mem_respond(0, 0);
        tick();
        checks++;
        if ({bus.ImemReq, bus.ImemAddr} !== {1'b1, 32'h8}) begin
            failures++;
            $display("FAIL bp_refetch: req/addr got %b/%h expected 1/00000008",
                     bus.ImemReq, bus.ImemAddr);
        end
        mem_respond(0, 0);
        tick();
        checks++;
        if ({bus.ImemReq, bus.OutPC} !== {1'b0, 32'h4}) begin
            failures++;
            $display("FAIL bp_refill: req/pc got %b/%h expected 0/00000004", bus.ImemReq, bus.OutPC);
        end
    endtask

    task automatic test_redirect_wait;
        bit seen;
        do_reset();
        bus.OutReady = 1'b1;
        mem_respond(2, 0);
        tick();
        mem_respond(2, 0);
        bus.RedirectValid  = 1'b1;
        bus.RedirectTarget = 32'h100;
        tick();
        bus.RedirectValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({bus.ImemReq, bus.ImemAddr} !== {1'b1, 32'h0}) begin
                failures++;
                $display("FAIL rw_hold_%0d: req/addr got %b/%h expected 1/00000000",
                         i, bus.ImemReq, bus.ImemAddr);
            end
            mem_respond(2, 0);
            tick();
        end
        checks++;
        if ({bus.ImemReq, bus.ImemAddr, bus.OutValid} !== {1'b1, 32'h100, 1'b0}) begin
            failures++;
            $display("FAIL rw_retarget: req/addr/valid got %b/%h/%b expected 1/00000100/0",
                     bus.ImemReq, bus.ImemAddr, bus.OutValid);
        end
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (bus.OutValid) seen = 1;
            else begin
                mem_respond(2, 0);
                tick();
            end
        end
        checks++;
        if ({seen, bus.OutPC, bus.Instruction} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
            failures++;
            $display("FAIL rw_first_out: seen/pc/instr got %b/%h/%h expected 1/00000100/%h",
                     seen, bus.OutPC, bus.Instruction, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_ack_pop;
        do_reset();
        bus.OutReady = 1'b1;
        mem_respond(0, 0);
        tick();
        mem_respond(0, 0);
        tick();
        checks++;
        if ({bus.OutValid, bus.ImemReq, bus.ImemAck} !== {1'b1, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL rap_setup: valid/req/ack got %b/%b/%b expected 1/1/1",
                     bus.OutValid, bus.ImemReq, bus.ImemAck);
        end
        mem_respond(0, 0);
        bus.RedirectValid  = 1'b1;
        bus.RedirectTarget = 32'h203;
        tick();
        bus.RedirectValid = 1'b0;
        checks++;
        if ({bus.OutValid, bus.ImemReq, bus.ImemAddr} !== {1'b0, 1'b1, 32'h200}) begin
            failures++;
            $display("FAIL rap_flush: valid/req/addr got %b/%b/%h expected 0/1/00000200",
                     bus.OutValid, bus.ImemReq, bus.ImemAddr);
        end
        mem_respond(0, 0);
        tick();
        checks++;
        if ({bus.OutValid, bus.OutPC, bus.Instruction} !== {1'b1, 32'h200, mem_word(32'h200)}) begin
            failures++;
            $display("FAIL rap_first_out: valid/pc/instr got %b/%h/%h expected 1/00000200/%h",
                     bus.OutValid, bus.OutPC, bus.Instruction, mem_word(32'h200));
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.OutReady = 1'b0;
        mem_respond(0, 0);
        tick();
        mem_respond(0, 0);
        tick();
        mem_respond(0, 0);
        Reset              = 1'b1;
        bus.RedirectValid  = 1'b1;
        bus.RedirectTarget = 32'h400;
        tick();
        Reset             = 1'b0;
        bus.RedirectValid = 1'b0;
        mem_busy          = 0;
        checks++;
        if ({bus.ImemReq, bus.OutValid, bus.ImemAddr, bus.Instruction, bus.OutPC} !==
            {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL rm_abandon: req/valid/addr/instr/pc got %b/%b/%h/%h/%h expected 0/0/0/0/0",
                     bus.ImemReq, bus.OutValid, bus.ImemAddr, bus.Instruction, bus.OutPC);
        end
        bus.ImemAck  = 1'b1;
        bus.ImemData = 32'hDEAD_BEEF;
        tick();
        checks++;
        if ({bus.ImemReq, bus.ImemAddr, bus.OutValid} !== {1'b1, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL rm_stray_ack: req/addr/valid got %b/%h/%b expected 1/00000000/0",
                     bus.ImemReq, bus.ImemAddr, bus.OutValid);
        end
        mem_respond(0, 0);
        tick();
        checks++;
        if ({bus.OutValid, bus.OutPC, bus.Instruction} !== {1'b1, 32'h0, mem_word(32'h0)}) begin
            failures++;
            $display("FAIL rm_restart: valid/pc/instr got %b/%h/%h expected 1/00000000/%h",
                     bus.OutValid, bus.OutPC, bus.Instruction, mem_word(32'h0));
        end
    endtask

    task automatic test_wrap;
        Reset2 = 1'b1;
        tick();
        tick();
        Reset2 = 1'b0;
        checks++;
        if ({bus2.ImemReq, bus2.ImemAddr, bus2.OutPCPlus4} !== {1'b0, 32'hFFFF_FFFC, 32'h4}) begin
            failures++;
            $display("FAIL wrap_reset: req/addr/pc4 got %b/%h/%h expected 0/fffffffc/00000004",
                     bus2.ImemReq, bus2.ImemAddr, bus2.OutPCPlus4);
        end
        tick();
        tick();
        checks++;
        if ({bus2.OutValid, bus2.OutPC, bus2.OutPCPlus4, bus2.Instruction, bus2.ImemAddr} !==
            {1'b1, 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC), 32'h0}) begin
            failures++;
            $display("FAIL wrap_first: valid/pc/pc4/instr/addr got %b/%h/%h/%h/%h expected 1/fffffffc/00000000/%h/00000000",
                     bus2.OutValid, bus2.OutPC, bus2.OutPCPlus4, bus2.Instruction, bus2.ImemAddr,
                     mem_word(32'hFFFF_FFFC));
        end
        tick();
        checks++;
        if ({bus2.OutValid, bus2.OutPC, bus2.OutPCPlus4} !== {1'b1, 32'h0, 32'h4}) begin
            failures++;
            $display("FAIL wrap_second: valid/pc/pc4 got %b/%h/%h expected 1/00000000/00000004",
                     bus2.OutValid, bus2.OutPC, bus2.OutPCPlus4);
        end
    endtask

    // Model: decode must see an unbroken +4 stream from the last redirect target,
    // each word matching memory, with no output the cycle after a redirect.
    task automatic test_random;
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        bit          prev_req;
        bit          prev_ack;
        bit          prev_redir;
        bit          redir;
        int          idle;
        int          max_idle;
        int          delivered;
        do_reset();
        exp_pc     = 32'h0;
        prev_addr  = 32'h0;
        prev_req   = 0;
        prev_ack   = 0;
        prev_redir = 0;
        idle       = 0;
        max_idle   = 0;
        delivered  = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (prev_req && !prev_ack) begin
                checks++;
                if ({bus.ImemReq, bus.ImemAddr} !== {1'b1, prev_addr}) begin
                    failures++;
                    $display("FAIL rnd_hold cyc %0d: req/addr got %b/%h expected 1/%h",
                             cyc, bus.ImemReq, bus.ImemAddr, prev_addr);
                end
            end
            if (prev_redir) begin
                checks++;
                if (bus.OutValid !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_flush cyc %0d: valid got %b expected 0", cyc, bus.OutValid);
                end
            end
            bus.OutReady      = ($urandom_range(0, 9) < 7);
            redir             = ($urandom_range(0, 19) == 0);
            bus.RedirectValid = redir;
            bus.RedirectTarget = ($urandom_range(0, 3) == 0) ?
                                 (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) :
                                 (32'($urandom) & 32'h0000_3FFF);
            mem_respond($urandom_range(0, 3), 1);
            if (bus.OutValid && bus.OutReady && !redir) begin
                checks++;
                if ({bus.OutPC, bus.Instruction, bus.OutPCPlus4} !==
                    {exp_pc, mem_word(exp_pc), exp_pc + 32'd4}) begin
                    failures++;
                    $display("FAIL rnd_out cyc %0d: pc/instr/pc4 got %h/%h/%h expected %h/%h/%h",
                             cyc, bus.OutPC, bus.Instruction, bus.OutPCPlus4,
                             exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
                end
                exp_pc    = exp_pc + 32'd4;
                delivered++;
                idle = 0;
            end else begin
                idle++;
            end
            if (redir) begin
                exp_pc = bus.RedirectTarget & ~32'h3;
                idle   = 0;
            end
            if (idle > max_idle) max_idle = idle;
            prev_req   = bus.ImemReq;
            prev_addr  = bus.ImemAddr;
            prev_ack   = bus.ImemAck;
            prev_redir = redir;
            tick();
        end
        checks++;
        if (max_idle > 60 || delivered < 500) begin
            failures++;
            $display("FAIL rnd_progress: max_idle/delivered got %0d/%0d required <=60/>=500",
                     max_idle, delivered);
        end
    endtask

    initial begin
        Reset              = 1'b1;
        Reset2             = 1'b1;
        bus.RedirectValid  = 1'b0;
        bus.RedirectTarget = 32'h0;
        bus.OutReady       = 1'b0;
        bus.ImemAck        = 1'b0;
        bus.ImemData       = 32'h0;
        bus2.RedirectValid  = 1'b0;
        bus2.RedirectTarget = 32'h0;
        bus2.OutReady       = 1'b1;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_reset_mid();
        test_wrap();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
